red_pitaya_iq_cordic_phase_block: RTL and testbench

//  Phase/amplitude detector, the inverse of the IQ function generator: takes a signed
//  (I=cos, Q=sin) sample pair and returns phase, magnitude and phase increment
//  (frequency) per valid sample. Pipelined CORDIC in vectoring mode; one sample per clock.

---
 rtl/red_pitaya_iq_cordic_phase_block.sv | 244 ++++++++++++++++++++++++
 tb/tb_red_pitaya_iq_cordic_phase_block.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_iq_cordic_phase_block.sv
// -----------------------------------------------------------------------------
// red_pitaya_iq_cordic_phase_block
//
// Phase / amplitude detector, the inverse of the IQ function generator. Each
// valid signed (I=cos, Q=sin) sample pair is run through a fully pipelined
// vectoring-mode CORDIC, which accepts one sample per clock. The block returns:
//   phase_o : atan2(q, i) as an unsigned phase, full turn = 2**PHASEBITS
//   mag_o   : sqrt(i^2 + q^2) * K, K ~= 1.64676 (CORDIC gain left in)
//   freq_o  : phase increment against the previous valid output, mod 2**PHASEBITS
// The phase convention matches the generator, so in loopback phase_o tracks the
// generator phase and freq_o tracks its phase step.
//
// Pipeline (valid_i sampled at edge n -> valid_o high after edge n+STAGES+2):
//   input register -> pre-rotation (stage P) -> STAGES micro-rotations
//   -> output register (zero forcing, phase difference)
//
// Ports
//   clk_i    in   1           system clock
//   rstn_i   in   1           synchronous reset, active low
//   on       in   1           enable; 0 flushes the pipeline and zeroes outputs
//   valid_i  in   1           i_i/q_i valid this cycle
//   i_i      in   INBITS      signed in-phase (cos) component
//   q_i      in   INBITS      signed quadrature (sin) component
//   valid_o  out  1           one-cycle strobe: outputs updated
//   phase_o  out  PHASEBITS   unsigned phase 0..2**PHASEBITS-1
//   mag_o    out  INBITS+1    unsigned magnitude including CORDIC gain
//   freq_o   out  PHASEBITS   phase_o minus previous phase_o, wrapping
// -----------------------------------------------------------------------------
module red_pitaya_iq_cordic_phase_block #(
  parameter int INBITS    = 17,
  parameter int PHASEBITS = 32,
  parameter int STAGES    = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 on,
  input  logic                 valid_i,
  input  logic [INBITS-1:0]    i_i,
  input  logic [INBITS-1:0]    q_i,
  output logic                 valid_o,
  output logic [PHASEBITS-1:0] phase_o,
  output logic [INBITS:0]      mag_o,
  output logic [PHASEBITS-1:0] freq_o
);

  // Two guard bits: one for negating the most negative input, one for the
  // growth of x through the rotations (up to sqrt(2) * K).
  localparam int W = INBITS + 2;

  localparam real PI = 3.14159265358979323846;

  localparam logic [PHASEBITS-1:0] QUARTER_TURN = PHASEBITS'(1) << (PHASEBITS - 2);
  localparam logic [PHASEBITS-1:0] THREE_QUARTER_TURN = QUARTER_TURN + (QUARTER_TURN << 1);

  // Micro-rotation angles A[k] = round(atan(2**-k) * 2**PHASEBITS / (2*pi)),
  // fixed at elaboration. A[0] is exactly an eighth of a turn.
  function automatic logic [STAGES-1:0][PHASEBITS-1:0] atan_table();
    logic [STAGES-1:0][PHASEBITS-1:0] t;
    real r;
    for (int k = 0; k < STAGES; k++) begin
      r    = $atan(1.0 / (2.0 ** k)) * (2.0 ** PHASEBITS) / (2.0 * PI);
      t[k] = PHASEBITS'(longint'(r));
    end
    t[0] = PHASEBITS'(1) << (PHASEBITS - 3);
    return t;
  endfunction

  localparam logic [STAGES-1:0][PHASEBITS-1:0] ATAN = atan_table();

  // High when the pipeline may hold and advance samples; low flushes it.
  logic run;
  assign run = rstn_i & on;

  // ---------------------------------------------------------------------------
  // Input register
  // ---------------------------------------------------------------------------
  logic                     in_v_q;
  logic signed [INBITS-1:0] in_i_q;
  logic signed [INBITS-1:0] in_q_q;

  always_ff @(posedge clk_i) begin
    if (!run) begin
      in_v_q <= 1'b0;
    end else begin
      in_v_q <= valid_i;
    end
  end

  // NOTE: datapath registers carry no reset; only the valid bits that travel
  // with them are cleared, so stale data is never qualified as an output.
  always_ff @(posedge clk_i) begin
    if (valid_i) begin
      in_i_q <= i_i;
      in_q_q <= q_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage P: pre-rotation into the right half plane (x >= 0)
  // ---------------------------------------------------------------------------
  logic signed [W-1:0]    ext_i;
  logic signed [W-1:0]    ext_q;
  logic signed [W-1:0]    pre_x_d;
  logic signed [W-1:0]    pre_y_d;
  logic [PHASEBITS-1:0]   pre_z_d;
  logic                   pre_zero_d;

  assign ext_i = W'(in_i_q);
  assign ext_q = W'(in_q_q);

  // NOTE: every combinational output gets a default before any branch, so no
  // path through the block leaves a value unassigned (no inferred latch).
  always_comb begin
    pre_x_d = ext_i;
    pre_y_d = ext_q;
    pre_z_d = '0;
    if (ext_i[W-1]) begin
      if (!ext_q[W-1]) begin
        // Second quadrant: rotate by -90 degrees, remember +1/4 turn.
        pre_x_d = ext_q;
        pre_y_d = -ext_i;
        pre_z_d = QUARTER_TURN;
      end else begin
        // Third quadrant: rotate by +90 degrees, remember 3/4 turn.
        pre_x_d = -ext_q;
        pre_y_d = ext_i;
        pre_z_d = THREE_QUARTER_TURN;
      end
    end
  end

  // The zero input has no defined angle; flag it so the output stage can
  // force phase and magnitude to exact zero.
  assign pre_zero_d = (in_i_q == '0) && (in_q_q == '0);

  // ---------------------------------------------------------------------------
  // CORDIC pipeline. Index 0 is the stage P register; index k+1 holds the
  // result of micro-rotation k. The final y is never needed, so y stops one
  // stage early.
  // ---------------------------------------------------------------------------
  logic signed [W-1:0]  x_q [0:STAGES];
  logic signed [W-1:0]  x_d [0:STAGES];
  logic signed [W-1:0]  y_q [0:STAGES-1];
  logic signed [W-1:0]  y_d [0:STAGES-1];
  logic [PHASEBITS-1:0] z_q [0:STAGES];
  logic [PHASEBITS-1:0] z_d [0:STAGES];
  logic [STAGES:0]      v_q;
  logic [STAGES:0]      zero_q;

  // NOTE: combinational next-state logic uses blocking '=', the registers
  // below use non-blocking '<=' so all stages advance on the same edge.
  always_comb begin
    x_d[0] = pre_x_d;
    y_d[0] = pre_y_d;
    z_d[0] = pre_z_d;
    // y >= 0: rotate clockwise and add the angle; y < 0: the opposite.
    for (int k = 0; k < STAGES; k++) begin
      if (!y_q[k][W-1]) begin
        x_d[k+1] = x_q[k] + (y_q[k] >>> k);
        z_d[k+1] = z_q[k] + ATAN[k];
      end else begin
        x_d[k+1] = x_q[k] - (y_q[k] >>> k);
        z_d[k+1] = z_q[k] - ATAN[k];
      end
    end
    for (int k = 0; k < STAGES - 1; k++) begin
      if (!y_q[k][W-1]) begin
        y_d[k+1] = y_q[k] - (x_q[k] >>> k);
      end else begin
        y_d[k+1] = y_q[k] + (x_q[k] >>> k);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    x_q    <= x_d;
    y_q    <= y_d;
    z_q    <= z_d;
    zero_q <= {zero_q[STAGES-1:0], pre_zero_d};
  end

  // Valid bits shift alongside the data; a flush empties the whole pipe.
  always_ff @(posedge clk_i) begin
    if (!run) begin
      v_q <= '0;
    end else begin
      v_q <= {v_q[STAGES-1:0], in_v_q};
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic                 valid_q;
  logic [PHASEBITS-1:0] phase_q;
  logic [PHASEBITS-1:0] phase_d;
  logic [INBITS:0]      mag_q;
  logic [INBITS:0]      mag_d;
  logic [PHASEBITS-1:0] freq_q;
  logic [PHASEBITS-1:0] freq_d;
  logic                 have_prev_q;

  always_comb begin
    phase_d = z_q[STAGES];
    mag_d   = x_q[STAGES][INBITS:0];
    // x is never negative for legal input; clamp rather than wrap if it were.
    if (zero_q[STAGES] || x_q[STAGES][W-1]) begin
      mag_d = '0;
    end
    if (zero_q[STAGES]) begin
      phase_d = '0;
    end
    // phase_q still holds the previous valid phase here; the subtraction
    // wraps naturally modulo 2**PHASEBITS.
    freq_d = '0;
    if (have_prev_q) begin
      freq_d = phase_d - phase_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!run) begin
      valid_q     <= 1'b0;
      phase_q     <= '0;
      mag_q       <= '0;
      freq_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      valid_q <= v_q[STAGES];
      if (v_q[STAGES]) begin
        phase_q     <= phase_d;
        mag_q       <= mag_d;
        freq_q      <= freq_d;
        have_prev_q <= 1'b1;
      end
    end
  end

  assign valid_o = valid_q;
  assign phase_o = phase_q;
  assign mag_o   = mag_q;
  assign freq_o  = freq_q;

endmodule

// File: tb/tb_red_pitaya_iq_cordic_phase_block.sv
// -----------------------------------------------------------------------------
// Self-checking bench for red_pitaya_iq_cordic_phase_block.
// A behavioural model computes ideal phase/magnitude with real arithmetic
// (atan2, sqrt) and tracks output timing with a queue of pending samples;
// every cycle the DUT outputs are compared against it within the accuracy
// bounds. Table vectors and a few hand sequences cover the corner cases.
// -----------------------------------------------------------------------------
module tb_red_pitaya_iq_cordic_phase_block;

  localparam int INBITS    = 17;
  localparam int PHASEBITS = 32;
  localparam int STAGES    = 16;
  localparam int LAT       = STAGES + 2;
  localparam longint PTOL  = longint'(1) << (PHASEBITS - STAGES + 1);
  localparam longint MTOL  = STAGES + 2;
  localparam real    PI    = 3.14159265358979323846;
  localparam real    TURN  = 4294967296.0;

  logic                 clk = 1'b0;
  logic                 rstn_i = 1'b0;
  logic                 on = 1'b0;
  logic                 valid_i = 1'b0;
  logic [INBITS-1:0]    i_i = '0;
  logic [INBITS-1:0]    q_i = '0;
  logic                 valid_o;
  logic [PHASEBITS-1:0] phase_o;
  logic [INBITS:0]      mag_o;
  logic [PHASEBITS-1:0] freq_o;

  red_pitaya_iq_cordic_phase_block #(
    .INBITS   (INBITS),
    .PHASEBITS(PHASEBITS),
    .STAGES   (STAGES)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn_i),
    .on     (on),
    .valid_i(valid_i),
    .i_i    (i_i),
    .q_i    (q_i),
    .valid_o(valid_o),
    .phase_o(phase_o),
    .mag_o  (mag_o),
    .freq_o (freq_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_phase(input string name, input logic [31:0] act,
                             input logic [31:0] exp, input longint tol);
    logic signed [31:0] d;
    longint ad;
    d  = act - exp;
    ad = (d < 0) ? -longint'(d) : longint'(d);
    check(name, ad <= tol, longint'(act), longint'(exp));
  endtask

  task automatic check_mag(input string name, input longint act, input longint exp,
                           input longint tol);
    longint ad;
    ad = (act > exp) ? act - exp : exp - act;
    check(name, ad <= tol, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int due;
    int i;
    int q;
  } pend_t;

  pend_t       pend[$];
  int          cyc = 0;
  real         kgain;
  logic        m_valid = 1'b0;
  logic [31:0] m_phase = '0;
  logic [31:0] m_freq = '0;
  longint      m_mag = 0;
  longint      m_ptol = 0;
  longint      m_mtol = 0;
  longint      m_ftol = 0;
  bit          m_have_prev = 1'b0;
  int          vo_count = 0;

  function automatic logic [31:0] ideal_phase(input int i, input int q);
    real a;
    if (i == 0 && q == 0) return 32'h0;
    a = $atan2(real'(q), real'(i)) / (2.0 * PI) * TURN;
    if (a < 0.0) a = a + TURN;
    return 32'(longint'(a));
  endfunction

  function automatic longint ideal_mag(input int i, input int q);
    longint li, lq;
    li = i;
    lq = q;
    return longint'($sqrt(real'(li * li + lq * lq)) * kgain);
  endfunction

  task automatic model_edge(input logic rst_n_v, input logic on_v, input logic v,
                            input int ii, input int qq);
    pend_t p;
    logic [31:0] ph;
    longint cur_ptol;
    cyc++;
    if (!rst_n_v || !on_v) begin
      pend.delete();
      m_valid = 1'b0;
      m_phase = '0;
      m_freq = '0;
      m_mag = 0;
      m_ptol = 0;
      m_mtol = 0;
      m_ftol = 0;
      m_have_prev = 1'b0;
      return;
    end
    if (v) begin
      p.due = cyc + LAT;
      p.i = ii;
      p.q = qq;
      pend.push_back(p);
    end
    m_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      ph = ideal_phase(p.i, p.q);
      cur_ptol = (p.i == 0 && p.q == 0) ? 0 : PTOL;
      if (m_have_prev) begin
        m_freq = ph - m_phase;
        m_ftol = cur_ptol + m_ptol;
      end else begin
        m_freq = '0;
        m_ftol = 0;
      end
      m_phase = ph;
      m_ptol = cur_ptol;
      m_mag = ideal_mag(p.i, p.q);
      m_mtol = (p.i == 0 && p.q == 0) ? 0 : MTOL;
      m_have_prev = 1'b1;
      m_valid = 1'b1;
    end
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, compare 1 time unit later.
  task automatic step(input logic rst_n_v, input logic on_v, input logic v,
                      input int ii, input int qq);
    @(negedge clk);
    rstn_i  = rst_n_v;
    on      = on_v;
    valid_i = v;
    i_i     = ii[INBITS-1:0];
    q_i     = qq[INBITS-1:0];
    @(posedge clk);
    model_edge(rst_n_v, on_v, v, ii, qq);
    #1;
    if (valid_o) vo_count++;
    check("valid_o", valid_o == m_valid, longint'(valid_o), longint'(m_valid));
    check_phase("phase_o", phase_o, m_phase, m_ptol);
    check_mag("mag_o", longint'(mag_o), m_mag, m_mtol);
    check_phase("freq_o", freq_o, m_freq, m_ftol);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  function automatic int amp_cos(input logic [31:0] ph);
    return int'($floor(65535.0 * $cos(2.0 * PI * real'(ph) / TURN) + 0.5));
  endfunction

  function automatic int amp_sin(input logic [31:0] ph);
    return int'($floor(65535.0 * $sin(2.0 * PI * real'(ph) / TURN) + 0.5));
  endfunction

  // ---------------------------------------------------------------------------
  // Table vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    int          i;
    int          q;
    logic [31:0] exp_phase;
    longint      exp_mag;
    bit          chk_freq;
  } vec_t;

  vec_t tab[6];

  initial begin
    int ri, rq;
    longint li, lq;
    logic [31:0] gph;

    kgain = 1.0;
    for (int k = 0; k < STAGES; k++) kgain = kgain * $sqrt(1.0 + 1.0 / (4.0 ** k));

    tab[0] = '{"pos_i",   65535,      0, 32'h0000_0000, 107921, 1'b1};
    tab[1] = '{"pos_q",       0,  65535, 32'h4000_0000, 107921, 1'b0};
    tab[2] = '{"neg_i",  -65535,      0, 32'h8000_0000, 107921, 1'b0};
    tab[3] = '{"neg_q",       0, -65535, 32'hC000_0000, 107921, 1'b0};
    tab[4] = '{"zero",        0,      0, 32'h0000_0000,      0, 1'b0};
    tab[5] = '{"min_iq", -65536, -65536, 32'hA000_0000, 152625, 1'b0};

    // Reset: outputs must read zero.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1234, -777);

    // Axis points, zero input and most-negative corner, one at a time.
    foreach (tab[t]) begin
      longint ptol;
      ptol = (tab[t].i == 0 && tab[t].q == 0) ? 0 : PTOL;
      step(1'b1, 1'b1, 1'b1, tab[t].i, tab[t].q);
      idle(LAT);
      check({"tab_valid_", tab[t].name}, valid_o == 1'b1, longint'(valid_o), 1);
      check_phase({"tab_phase_", tab[t].name}, phase_o, tab[t].exp_phase, ptol);
      check_mag({"tab_mag_", tab[t].name}, longint'(mag_o), tab[t].exp_mag,
                (ptol == 0) ? 0 : MTOL);
      if (tab[t].chk_freq)
        check({"tab_freq_", tab[t].name}, freq_o == 32'h0, longint'(freq_o), 0);
    end

    // Phase wrap: 0xFF000000 followed by 0x01000000 gives a step of 0x02000000.
    step(1'b1, 1'b1, 1'b1, amp_cos(32'hFF00_0000), amp_sin(32'hFF00_0000));
    step(1'b1, 1'b1, 1'b1, amp_cos(32'h0100_0000), amp_sin(32'h0100_0000));
    idle(LAT);
    check_phase("wrap_freq", freq_o, 32'h0200_0000, 2 * PTOL + 32768);

    // Loopback from a generator stepping 2**24 per sample; restart first so
    // the first emitted freq_o is zero.
    step(1'b1, 1'b0, 1'b0, 0, 0);
    gph = 32'h1234_5678;
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 1'b1, 1'b1, amp_cos(gph), amp_sin(gph));
      gph = gph + 32'h0100_0000;
    end
    idle(LAT);
    check_phase("loop_freq", freq_o, 32'h0100_0000, 2 * PTOL + 32768);

    // valid_i 1,0,1: the same pattern must appear LAT cycles later.
    step(1'b1, 1'b1, 1'b1, 30000, 20000);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b1, -30000, 20000);
    idle(LAT + 2);

    // on dropped for one cycle mid-burst: only the post-drop samples emerge.
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b1, 40000 - 9000 * k, 25000);
    step(1'b1, 1'b0, 1'b1, 50000, 50000);
    check("on_drop_zero", (phase_o == 0) && (mag_o == 0) && (freq_o == 0) && !valid_o,
          longint'(mag_o), 0);
    vo_count = 0;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, -20000, -40000 + 7000 * k);
    idle(LAT + 4);
    check("on_drop_count", vo_count == 4, longint'(vo_count), 4);

    // Randomized stream: gaps, occasional zero input, magnitude kept in the
    // accurate range.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        ri = 0;
        rq = 0;
      end else begin
        do begin
          ri = int'($urandom_range(0, 131071)) - 65536;
          rq = int'($urandom_range(0, 131071)) - 65536;
          li = ri;
          lq = rq;
        end while (li * li + lq * lq < (longint'(1) << 28));
      end
      step(1'b1, 1'b1, ($urandom_range(0, 9) < 7), ri, rq);
    end
    idle(LAT);

    // Synchronous reset mid-stream discards the pipeline.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 10000 * k - 20000, 30000);
    step(1'b0, 1'b1, 1'b1, 0, 0);
    vo_count = 0;
    idle(LAT + 2);
    check("reset_flush_count", vo_count == 0, longint'(vo_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
